// File: rtl/hazard_if.sv
// Pipeline-side hazard signals: ID/EX source and destination info in, stall/flush controls out.
interface hazard_if;
  logic [4:0] regfile_read_num1_id;
  logic [4:0] regfile_read_num2_id;
  logic       rs_used_id;
  logic       rt_used_id;
  logic       md_read_id;
  logic       MemRead_id_ex;
  logic [4:0] regfile_write_num_id_ex;
  logic       md_start_ex;
  logic       md_is_div_ex;
  logic       branch_taken_ex;
  logic       syscall_halt_ex;
  logic       pc_stall;
  logic       if_id_stall;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       md_busy;
  logic       halted;

  modport master (
    output regfile_read_num1_id, regfile_read_num2_id, rs_used_id, rt_used_id,
           md_read_id, MemRead_id_ex, regfile_write_num_id_ex, md_start_ex,
           md_is_div_ex, branch_taken_ex, syscall_halt_ex,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, md_busy, halted
  );

  modport slave (
    input  regfile_read_num1_id, regfile_read_num2_id, rs_used_id, rt_used_id,
           md_read_id, MemRead_id_ex, regfile_write_num_id_ex, md_start_ex,
           md_is_div_ex, branch_taken_ex, syscall_halt_ex,
    output pc_stall, if_id_stall, if_id_flush, id_ex_flush, md_busy, halted
  );
endinterface

// File: rtl/hazard_unit.sv
// Stall/flush controller for load-use, mult/div busy, taken branch and syscall halt.
// Define HAZARD_STATS_EN to add saturating stall_cycles / flush_count outputs.
//
// state   | meaning
// IDLE    | HI/LO unit free, no halt
// MD_BUSY | mult/div in progress, md_cnt counts down remaining cycles
// HALT    | core halted by syscall, sticky until rst
module hazard_unit #(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 32,
  parameter int CNT_W       = 16
) (
  input  logic           clk,
  input  logic           rst,
  hazard_if.slave        hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  localparam int MAX_LAT  = (DIV_LATENCY > MUL_LATENCY) ? DIV_LATENCY : MUL_LATENCY;
  localparam int CNT_BITS = $clog2(MAX_LAT) + 1;

  if (MUL_LATENCY < 1 || DIV_LATENCY < 1 || CNT_W < 1) begin : g_param_check
    $error("hazard_unit: latencies and CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    HALT    = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_BITS-1:0] md_cnt, md_cnt_nxt;
  logic                load_use;
  logic                md_hazard;
  logic                halt_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    md_cnt_nxt     = md_cnt;
    hz.pc_stall    = 1'b0;
    hz.if_id_stall = 1'b0;
    hz.if_id_flush = 1'b0;
    hz.id_ex_flush = 1'b0;

    load_use = hz.MemRead_id_ex && (hz.regfile_write_num_id_ex != 5'd0) &&
               ((hz.rs_used_id && (hz.regfile_read_num1_id == hz.regfile_write_num_id_ex)) ||
                (hz.rt_used_id && (hz.regfile_read_num2_id == hz.regfile_write_num_id_ex)));
    md_hazard   = hz.md_read_id && (state == MD_BUSY) && (md_cnt != '0);
    halt_active = (state == HALT) || hz.syscall_halt_ex;

    case (state)
      IDLE, MD_BUSY: begin
        // A start while busy simply reloads the count; the older op is overwritten.
        if (hz.md_start_ex) begin
          state_nxt  = MD_BUSY;
          md_cnt_nxt = hz.md_is_div_ex ? CNT_BITS'(DIV_LATENCY - 1)
                                       : CNT_BITS'(MUL_LATENCY - 1);
        end else if (state == MD_BUSY) begin
          if (md_cnt == '0) state_nxt = IDLE;
          else              md_cnt_nxt = md_cnt - 1'b1;
        end
      end
      HALT: begin
        state_nxt  = HALT;
        md_cnt_nxt = '0;
      end
      default: begin
        state_nxt  = IDLE;
        md_cnt_nxt = '0;
      end
    endcase

    if (hz.syscall_halt_ex) begin
      state_nxt  = HALT;
      md_cnt_nxt = '0;
    end

    if (rst) begin
      hz.pc_stall    = 1'b0;
    end else if (halt_active) begin
      hz.pc_stall    = 1'b1;
      hz.if_id_stall = 1'b1;
      hz.id_ex_flush = 1'b1;
    end else if (hz.branch_taken_ex) begin
      // ID instruction is in the branch shadow, so its hazards do not matter.
      hz.if_id_flush = 1'b1;
      hz.id_ex_flush = 1'b1;
    end else if (load_use || md_hazard) begin
      hz.pc_stall    = 1'b1;
      hz.if_id_stall = 1'b1;
      hz.id_ex_flush = 1'b1;
    end
  end

  assign hz.md_busy = (state == MD_BUSY);
  assign hz.halted  = (state == HALT);

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (hz.pc_stall && (state != HALT) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (hz.branch_taken_ex && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: vector table for single-cycle hazards plus cycle sequences.
module tb_hazard_unit;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hazard_if hz();

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles, flush_count;
  hazard_unit dut (.clk(clk), .rst(rst), .hz(hz),
                   .stall_cycles(stall_cycles), .flush_count(flush_count));
`else
  hazard_unit dut (.clk(clk), .rst(rst), .hz(hz));
`endif

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rs_used;
    logic       rt_used;
    logic       md_read;
    logic       mem_read;
    logic [4:0] wnum;
    logic       branch;
    logic [3:0] exp;   // {pc_stall, if_id_stall, if_id_flush, id_ex_flush}
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    hz.regfile_read_num1_id    = 5'd0;
    hz.regfile_read_num2_id    = 5'd0;
    hz.rs_used_id              = 1'b0;
    hz.rt_used_id              = 1'b0;
    hz.md_read_id              = 1'b0;
    hz.MemRead_id_ex           = 1'b0;
    hz.regfile_write_num_id_ex = 5'd0;
    hz.md_start_ex             = 1'b0;
    hz.md_is_div_ex            = 1'b0;
    hz.branch_taken_ex         = 1'b0;
    hz.syscall_halt_ex         = 1'b0;
  endtask

  task automatic load_use_on(input logic [4:0] r);
    hz.MemRead_id_ex           = 1'b1;
    hz.regfile_write_num_id_ex = r;
    hz.regfile_read_num1_id    = r;
    hz.rs_used_id              = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ctl();
    return {hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.id_ex_flush};
  endfunction

  initial begin
    vecs[0] = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 4'b1101};
    vecs[1] = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 4'b0000};
    vecs[2] = '{5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 4'b0000};
    vecs[3] = '{5'd3, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 4'b1101};
    vecs[4] = '{5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 4'b0000};
    vecs[5] = '{5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 4'b0000};
    vecs[6] = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 4'b0011};
    vecs[7] = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 4'b0011};
    vecs[8] = '{5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 4'b0000};
    vecs[9] = '{5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 4'b0000};

    // Reset: outputs forced low even with a live load-use pattern.
    idle_inputs();
    rst = 1'b1;
    #1;
    load_use_on(5'd8);
    @(negedge clk);
    check("rst_forces_ctl", 32'(ctl()), 32'h0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("rst_md_busy", 32'(hz.md_busy), 32'h0);
    check("rst_halted", 32'(hz.halted), 32'h0);
    check("rst_idle_ctl", 32'(ctl()), 32'h0);
    next_cycle();

    // Single-cycle hazard table, applied in IDLE.
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      hz.regfile_read_num1_id    = vecs[i].rs;
      hz.regfile_read_num2_id    = vecs[i].rt;
      hz.rs_used_id              = vecs[i].rs_used;
      hz.rt_used_id              = vecs[i].rt_used;
      hz.md_read_id              = vecs[i].md_read;
      hz.MemRead_id_ex           = vecs[i].mem_read;
      hz.regfile_write_num_id_ex = vecs[i].wnum;
      hz.branch_taken_ex         = vecs[i].branch;
      @(negedge clk);
      check($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vecs[i].exp));
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    check("load_use_one_cycle", 32'(ctl()), 32'h0);
    next_cycle();

    // Divide with mflo waiting in ID: stall k=1..31, busy k=1..32.
    for (int k = 0; k <= 33; k++) begin
      idle_inputs();
      hz.md_start_ex  = (k == 0);
      hz.md_is_div_ex = 1'b1;
      hz.md_read_id   = 1'b1;
      @(negedge clk);
      check($sformatf("div_stall_k%0d", k), 32'(hz.pc_stall), 32'(k >= 1 && k <= 31));
      check($sformatf("div_flush_k%0d", k), 32'(hz.id_ex_flush), 32'(k >= 1 && k <= 31));
      check($sformatf("div_busy_k%0d", k), 32'(hz.md_busy), 32'(k >= 1 && k <= 32));
      next_cycle();
    end

    // Multiply: stall k=1..3, busy k=1..4.
    for (int k = 0; k <= 6; k++) begin
      idle_inputs();
      hz.md_start_ex = (k == 0);
      hz.md_read_id  = 1'b1;
      @(negedge clk);
      check($sformatf("mul_stall_k%0d", k), 32'(hz.if_id_stall), 32'(k >= 1 && k <= 3));
      check($sformatf("mul_busy_k%0d", k), 32'(hz.md_busy), 32'(k >= 1 && k <= 4));
      next_cycle();
    end

    // Multiply at k=0, divide restart at k=2: busy k=1..34.
    for (int k = 0; k <= 36; k++) begin
      idle_inputs();
      hz.md_start_ex  = (k == 0) || (k == 2);
      hz.md_is_div_ex = (k == 2);
      @(negedge clk);
      check($sformatf("restart_busy_k%0d", k), 32'(hz.md_busy), 32'(k >= 1 && k <= 34));
      next_cycle();
    end

    // Load-use and start in the same cycle both take effect.
    idle_inputs();
    load_use_on(5'd5);
    hz.md_start_ex = 1'b1;
    @(negedge clk);
    check("lu_start_ctl", 32'(ctl()), 32'hD);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("lu_start_busy", 32'(hz.md_busy), 32'h1);
    for (int k = 0; k < 6; k++) next_cycle();

    // Branch with a divide start: flush, start still accepted.
    idle_inputs();
    load_use_on(5'd6);
    hz.branch_taken_ex = 1'b1;
    hz.md_start_ex     = 1'b1;
    hz.md_is_div_ex    = 1'b1;
    @(negedge clk);
    check("br_start_ctl", 32'(ctl()), 32'h3);
    next_cycle();
    idle_inputs();
    hz.md_read_id      = 1'b1;
    hz.branch_taken_ex = 1'b1;
    @(negedge clk);
    check("br_start_busy", 32'(hz.md_busy), 32'h1);
    check("br_over_md_ctl", 32'(ctl()), 32'h3);
    next_cycle();

    // Reset mid-divide aborts the count.
    idle_inputs();
    hz.md_read_id = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_div_ctl", 32'(ctl()), 32'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_div_busy", 32'(hz.md_busy), 32'h0);
    check("rst_mid_div_nostall", 32'(hz.pc_stall), 32'h0);
    next_cycle();

    // Halt: immediate outputs, sticky, ignores branch/MD, cleared by rst.
    idle_inputs();
    hz.syscall_halt_ex = 1'b1;
    hz.branch_taken_ex = 1'b1;
    @(negedge clk);
    check("sys_cycle_ctl", 32'(ctl()), 32'hD);
    check("sys_cycle_halted", 32'(hz.halted), 32'h0);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      idle_inputs();
      hz.branch_taken_ex = 1'b1;
      hz.md_start_ex     = 1'b1;
      @(negedge clk);
      check($sformatf("halt_k%0d_halted", k), 32'(hz.halted), 32'h1);
      check($sformatf("halt_k%0d_ctl", k), 32'(ctl()), 32'hD);
      check($sformatf("halt_k%0d_busy", k), 32'(hz.md_busy), 32'h0);
      next_cycle();
    end
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    check("halt_rst_ctl", 32'(ctl()), 32'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("after_halt_halted", 32'(hz.halted), 32'h0);
    check("after_halt_ctl", 32'(ctl()), 32'h0);
    check("after_halt_busy", 32'(hz.md_busy), 32'h0);
    next_cycle();

`ifdef HAZARD_STATS_EN
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      load_use_on(5'd4);
      next_cycle();
    end
    for (int k = 0; k < 2; k++) begin
      idle_inputs();
      hz.branch_taken_ex = 1'b1;
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    check("stats_stall_cycles", 32'(stall_cycles), 32'd3);
    check("stats_flush_count", 32'(flush_count), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
